// File: rtl/cube_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cube_mem_pkg
//  Purpose   : Shared types and constants for the cube result-memory reader.
//              - state_t     : reader FSM state encoding
//              - c_BASE_ADDR : first word of the cube datapath result window
//              - c_COUNT     : number of words in that window
//              - c_CSUM_ADDR : all-ones address tag for the checksum beat
//  Revision  : 1.0  initial release
// ============================================================================
package cube_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4,
    CSUM = 3'd5
  } state_t;

  // The cube datapath writes its results into data memory words 20..30.
  localparam int c_BASE_ADDR = 20;
  localparam int c_COUNT     = 11;

  // Wide enough for any practical address width; sliced down by the user.
  localparam logic [31:0] c_CSUM_ADDR = '1;

endpackage
`default_nettype wire

// File: rtl/cube_mem_reader.sv
`default_nettype none
// ============================================================================
//  Module    : cube_mem_reader
//  Purpose   : On a start pulse, reads COUNT consecutive words starting at
//              BASE_ADDR through a synchronous (1-cycle latency) read port
//              and emits each as an {addr, data} beat on a valid/ready
//              stream. One beat every 3 cycles at full downstream rate.
//  Option    : CUBE_MEM_READER_CSUM_EN - when defined, one extra beat with
//              out_addr = all-ones and out_data = sum of the data words
//              (mod 2**DATA_W) follows the data beats and carries out_last.
//  Ports     : clk, rst_n              clock, async active-low reset
//              start, busy, done       dump request / in-progress / finished
//              mem_re, mem_addr,
//              mem_rdata               synchronous memory read port
//              out_valid, out_ready,
//              out_addr, out_data,
//              out_last                output beat stream
//  Revision  : 1.0  initial release
// ============================================================================
module cube_mem_reader
  import cube_mem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = c_BASE_ADDR,
  parameter int COUNT     = c_COUNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int                  c_IDX_W    = $clog2(COUNT + 1);
  localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(COUNT - 1);
  localparam logic [ADDR_W-1:0]   c_BASE     = ADDR_W'(BASE_ADDR);

  if (COUNT < 1) begin : g_count_chk
    $error("cube_mem_reader: COUNT must be at least 1");
  end

  state_t             r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic               w_at_last;
  logic [ADDR_W-1:0]  w_next_addr;

  assign w_at_last   = (r_idx == c_LAST_IDX);
  // Only used while r_idx < COUNT-1, so the parameter range rules out wrap.
  assign w_next_addr = c_BASE + ADDR_W'(r_idx + 1'b1);

`ifdef CUBE_MEM_READER_CSUM_EN
  localparam logic [ADDR_W-1:0] c_CSUM_OUT_ADDR = c_CSUM_ADDR[ADDR_W-1:0];
  logic [DATA_W-1:0] r_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef CUBE_MEM_READER_CSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Read request is registered here so mem_re is high in REQ.
            r_idx    <= '0;
            busy     <= 1'b1;
            mem_re   <= 1'b1;
            mem_addr <= c_BASE;
            r_state  <= REQ;
`ifdef CUBE_MEM_READER_CSUM_EN
            r_sum    <= '0;
`endif
          end
        end

        REQ: begin
          mem_re  <= 1'b0;
          r_state <= CAP;
        end

        CAP: begin
          out_data  <= mem_rdata;
          out_addr  <= mem_addr;
          out_valid <= 1'b1;
`ifdef CUBE_MEM_READER_CSUM_EN
          out_last  <= 1'b0;
          r_sum     <= r_sum + mem_rdata;
`else
          out_last  <= w_at_last;
`endif
          r_state   <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (w_at_last) begin
`ifdef CUBE_MEM_READER_CSUM_EN
              // Checksum beat follows immediately; r_sum already holds the
              // last word captured in CAP.
              out_valid <= 1'b1;
              out_addr  <= c_CSUM_OUT_ADDR;
              out_data  <= r_sum;
              out_last  <= 1'b1;
              r_state   <= CSUM;
`else
              done      <= 1'b1;
              busy      <= 1'b0;
              r_state   <= FIN;
`endif
            end else begin
              r_idx    <= r_idx + 1'b1;
              mem_re   <= 1'b1;
              mem_addr <= w_next_addr;
              r_state  <= REQ;
            end
          end
        end

`ifdef CUBE_MEM_READER_CSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= FIN;
          end
        end
`endif

        FIN: begin
          // start is deliberately not looked at here.
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
